// File: rtl/conv_window_gen.sv
// Sliding KxK window generator for a raster-order greyscale pixel stream.
// Buffers K-1 rows and emits one registered window per accepted pixel once K rows are available.
module conv_window_gen #(
  parameter int IMG_DIM  = 30,
  parameter int K        = 3,
  parameter int GS_BITS  = 8,
  parameter int POS_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GS_BITS-1:0]        pixel_i,
  input  logic                      pixel_i_valid,
  output logic [K*K*GS_BITS-1:0]    win_o,
  output logic                      win_o_valid,
  output logic [POS_BITS-1:0]       win_row_o,
  output logic [POS_BITS-1:0]       win_col_o,
  output logic                      frame_done_o,
  output logic                      dbg_state_o
);

  // Stream protocol: valid-only, no ready. Every pixel with pixel_i_valid high is consumed
  // on that edge, and the consumer must take every cycle in which win_o_valid is high.

  localparam int CNT_W = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int WIN_W = K * K * GS_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_DIM - 1);
  localparam logic [CNT_W-1:0] KM1  = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] KM2  = CNT_W'(K - 2);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   col_cnt;
  logic [GS_BITS-1:0] mem [K-1][IMG_DIM];
  logic [WIN_W-1:0]   taps_q;
  logic [GS_BITS-1:0] new_col [K];
  logic [WIN_W-1:0]   win_next;
  logic               last_col;
  logic               last_pix;
  logic               emit;
  logic [CNT_W-1:0]   row_off;
  logic [CNT_W-1:0]   col_off;

  assign last_col    = (col_cnt == LAST);
  assign last_pix    = last_col && (row_cnt == LAST);
  assign emit        = pixel_i_valid && (state == STREAM) && (col_cnt >= KM1);
  assign row_off     = row_cnt - KM1;
  assign col_off     = col_cnt - KM1;
  assign dbg_state_o = state;

  // mem[r] holds the row that is K-1-r rows above the incoming one, indexed by column.
  always_comb begin
    new_col[K-1] = pixel_i;
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = mem[r][col_cnt];
    end
  end

  always_comb begin
    win_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[(r*K+c)*GS_BITS +: GS_BITS] = taps_q[(r*K+c+1)*GS_BITS +: GS_BITS];
      end
      win_next[(r*K+K-1)*GS_BITS +: GS_BITS] = new_col[r];
    end
  end

  // Storage is deliberately unreset: FILL blocks emission until every tap holds current-frame data.
  always_ff @(posedge clk) begin
    if (pixel_i_valid) begin
      taps_q <= win_next;
      for (int r = 0; r < K - 1; r++) begin
        mem[r][col_cnt] <= new_col[r+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      row_cnt      <= '0;
      col_cnt      <= '0;
      win_o        <= '0;
      win_o_valid  <= 1'b0;
      win_row_o    <= '0;
      win_col_o    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      win_o_valid  <= emit;
      frame_done_o <= emit && last_pix;
      if (emit) begin
        win_o     <= win_next;
        win_row_o <= POS_BITS'(row_off);
        win_col_o <= POS_BITS'(col_off);
      end
      if (pixel_i_valid) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_pix ? '0 : row_cnt + ONE;
        end else begin
          col_cnt <= col_cnt + ONE;
        end
        case (state)
          FILL:    if (last_col && (row_cnt == KM2)) state <= STREAM;
          STREAM:  if (last_pix) state <= FILL;
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: default 30x30/K=3 instance plus 8x8 K=2 and K=5 instances.
// Windows are captured at negedge and compared against a pixel-formula model in each test task.
module tb_conv_window_gen;

  localparam int DIM = 30;
  localparam int K   = 3;
  localparam int GS  = 8;
  localparam int PB  = 5;
  localparam int WW  = K * K * GS;
  localparam int MW  = 1 + 2 * PB + WW;
  localparam int NW  = (DIM - K + 1) * (DIM - K + 1);
  localparam int SD  = 8;
  localparam int W2  = 2 * 2 * GS;
  localparam int W5  = 5 * 5 * GS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [GS-1:0] pixel;
  logic          pv;
  logic [WW-1:0] win;
  logic          wv, fd, st;
  logic [PB-1:0] wr, wc;

  logic [GS-1:0] px_s;
  logic          pv_s;
  logic [W2-1:0] win2;
  logic [W5-1:0] win5;
  logic          wv2, fd2, st2, wv5, fd5, st5;
  logic [PB-1:0] wr2, wc2, wr5, wc5;

  conv_window_gen #(.IMG_DIM(DIM), .K(K), .GS_BITS(GS), .POS_BITS(PB)) dut (
    .clk(clk), .rst(rst), .pixel_i(pixel), .pixel_i_valid(pv),
    .win_o(win), .win_o_valid(wv), .win_row_o(wr), .win_col_o(wc),
    .frame_done_o(fd), .dbg_state_o(st)
  );

  conv_window_gen #(.IMG_DIM(SD), .K(2), .GS_BITS(GS), .POS_BITS(PB)) dut_k2 (
    .clk(clk), .rst(rst), .pixel_i(px_s), .pixel_i_valid(pv_s),
    .win_o(win2), .win_o_valid(wv2), .win_row_o(wr2), .win_col_o(wc2),
    .frame_done_o(fd2), .dbg_state_o(st2)
  );

  conv_window_gen #(.IMG_DIM(SD), .K(5), .GS_BITS(GS), .POS_BITS(PB)) dut_k5 (
    .clk(clk), .rst(rst), .pixel_i(px_s), .pixel_i_valid(pv_s),
    .win_o(win5), .win_o_valid(wv5), .win_row_o(wr5), .win_col_o(wc5),
    .frame_done_o(fd5), .dbg_state_o(st5)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mark_cyc = 0;
  int gap_bad  = 0;

  logic [MW-1:0]         obs_q[$];
  logic [MW-1:0]         exp_q[$];
  int                    obs_cyc_q[$];
  logic [2*PB+W2-1:0]    obs2_q[$];
  logic [2*PB+W2-1:0]    exp2_q[$];
  logic [2*PB+W5-1:0]    obs5_q[$];
  logic [2*PB+W5-1:0]    exp5_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture only; comparisons live in the test tasks.
  always @(negedge clk) begin
    if (!rst) begin
      if (wv) begin
        obs_q.push_back({fd, wr, wc, win});
        obs_cyc_q.push_back(cyc);
      end
      if (wv2) obs2_q.push_back({wr2, wc2, win2});
      if (wv5) obs5_q.push_back({wr5, wc5, win5});
    end
  end

  function automatic logic [W5-1:0] model_win(input int dim, input int k, input int r,
                                               input int c, input int off);
    logic [W5-1:0] w;
    w = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w[(i*k+j)*GS +: GS] = GS'(((r + i) * dim + c + j + off) % 256);
    return w;
  endfunction

  task automatic build_exp(input int off);
    logic [W5-1:0] w;
    for (int r = 0; r <= DIM - K; r++)
      for (int c = 0; c <= DIM - K; c++) begin
        w = model_win(DIM, K, r, c, off);
        exp_q.push_back({(r == DIM - K) && (c == DIM - K), PB'(r), PB'(c), w[WW-1:0]});
      end
  endtask

  task automatic clear_main();
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    pv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Pixel i of a frame is (i + off) mod 256, i.e. (r*DIM + c + off) mod 256.
  task automatic drive_frame(input int off, input int idle_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) < idle_pct) begin
        pv = 1'b0;
        @(negedge clk);
        if (wv !== 1'b0) gap_bad++;
      end
      pixel = GS'((i + off) % 256);
      pv    = 1'b1;
      if (i == (K - 1) * DIM + K - 1) mark_cyc = cyc + 1;
      @(negedge clk);
    end
  endtask

  function automatic int done_count();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][MW-1]) n++;
    return n;
  endfunction

  task automatic test_reset();
    checks++; if (wv !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", wv); end
    checks++; if (win !== '0) begin failures++; $display("FAIL reset_win: got %h expected 0", win); end
    checks++; if (wr !== '0) begin failures++; $display("FAIL reset_row: got %0d expected 0", wr); end
    checks++; if (wc !== '0) begin failures++; $display("FAIL reset_col: got %0d expected 0", wc); end
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", fd); end
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL reset_state: got %b expected 0 (FILL)", st); end
    checks++; if ({wv2, wv5} !== 2'b00) begin failures++; $display("FAIL reset_sweep_valid: got %b expected 00", {wv2, wv5}); end
  endtask

  task automatic test_single_frame();
    logic [MW-1:0] f0, f1, fl;
    int mism, bad_col;
    clear_main();
    build_exp(0);
    drive_frame(0, 0, DIM * DIM);
    idle(3);
    f0 = '1; f1 = '1; fl = '1;
    if (obs_q.size() > 0) begin f0 = obs_q[0]; fl = obs_q[obs_q.size()-1]; end
    if (obs_q.size() > 1) f1 = obs_q[1];
    checks++; if (obs_cyc_q.size() == 0 || obs_cyc_q[0] != mark_cyc) begin
      failures++; $display("FAIL first_latency: got cycle %0d expected %0d",
                           (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, mark_cyc); end
    checks++; if (f0[MW-2:WW+PB] !== 5'd0) begin failures++; $display("FAIL first_row: got %0d expected 0", f0[MW-2:WW+PB]); end
    checks++; if (f0[WW+PB-1:WW] !== 5'd0) begin failures++; $display("FAIL first_col: got %0d expected 0", f0[WW+PB-1:WW]); end
    checks++; if (f0[7:0] !== 8'h00) begin failures++; $display("FAIL first_tl: got %h expected 00", f0[7:0]); end
    checks++; if (f0[39:32] !== 8'h1F) begin failures++; $display("FAIL first_centre: got %h expected 1f", f0[39:32]); end
    checks++; if (f0[71:64] !== 8'h3E) begin failures++; $display("FAIL first_br: got %h expected 3e", f0[71:64]); end
    checks++; if (f1[WW+2*PB-1:WW] !== {5'd0, 5'd1}) begin failures++; $display("FAIL second_pos: got %h expected 001", f1[WW+2*PB-1:WW]); end
    checks++; if (f1[7:0] !== 8'h01) begin failures++; $display("FAIL second_tl: got %h expected 01", f1[7:0]); end
    checks++; if (fl[MW-1] !== 1'b1) begin failures++; $display("FAIL last_done: got %b expected 1", fl[MW-1]); end
    checks++; if (fl[WW+2*PB-1:WW] !== {5'd27, 5'd27}) begin failures++; $display("FAIL last_pos: got %h expected 37b", fl[WW+2*PB-1:WW]); end
    checks++; if (fl[7:0] !== 8'h45) begin failures++; $display("FAIL last_tl: got %h expected 45", fl[7:0]); end
    checks++; if (fl[39:32] !== 8'h64) begin failures++; $display("FAIL last_centre: got %h expected 64", fl[39:32]); end
    checks++; if (fl[71:64] !== 8'h83) begin failures++; $display("FAIL last_br: got %h expected 83", fl[71:64]); end
    checks++; if (obs_q.size() != NW) begin failures++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), NW); end
    checks++; if (done_count() != 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", done_count()); end
    bad_col = 0;
    foreach (obs_q[i]) if (obs_q[i][WW+PB-1:WW] > 5'(DIM - K)) bad_col++;
    checks++; if (bad_col != 0) begin failures++; $display("FAIL single_edge_cols: got %0d windows expected 0", bad_col); end
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL single_contents: window %0d got %h expected %h", mism, obs_q[mism], exp_q[mism]); end
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL single_end_state: got %b expected 0 (FILL)", st); end
  endtask

  task automatic test_gaps();
    int mism;
    clear_main();
    gap_bad = 0;
    build_exp(0);
    drive_frame(0, 40, DIM * DIM);
    idle(3);
    checks++; if (obs_q.size() != NW) begin failures++; $display("FAIL gaps_count: got %0d expected %0d", obs_q.size(), NW); end
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL gaps_valid_low: got %0d valid gap cycles expected 0", gap_bad); end
    checks++; if (done_count() != 1) begin failures++; $display("FAIL gaps_done_count: got %0d expected 1", done_count()); end
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL gaps_contents: window %0d got %h expected %h", mism, obs_q[mism], exp_q[mism]); end
  endtask

  task automatic test_back_to_back();
    int offs[3] = '{17, 101, 200};
    int mism;
    clear_main();
    foreach (offs[f]) build_exp(offs[f]);
    foreach (offs[f]) drive_frame(offs[f], 0, DIM * DIM);
    idle(3);
    checks++; if (obs_q.size() != 3 * NW) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), 3 * NW); end
    checks++; if (done_count() != 3) begin failures++; $display("FAIL b2b_done_count: got %0d expected 3", done_count()); end
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL b2b_contents: window %0d got %h expected %h", mism, obs_q[mism], exp_q[mism]); end
  endtask

  task automatic test_reset_mid_frame();
    int mism;
    clear_main();
    drive_frame(50, 0, 400);
    pv  = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({wv, fd} !== 2'b00) begin failures++; $display("FAIL midrst_flags: got %b expected 00", {wv, fd}); end
    checks++; if (win !== '0) begin failures++; $display("FAIL midrst_win: got %h expected 0", win); end
    checks++; if ({wr, wc} !== '0) begin failures++; $display("FAIL midrst_pos: got %h expected 0", {wr, wc}); end
    checks++; if (st !== 1'b0) begin failures++; $display("FAIL midrst_state: got %b expected 0", st); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({wv, fd, win} !== '0) begin failures++; $display("FAIL midrst_hold: got %h expected 0", {wv, fd, win}); end
    rst = 1'b0;
    clear_main();
    idle(3);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midrst_no_stale: got %0d windows expected 0", obs_q.size()); end
    build_exp(0);
    drive_frame(0, 0, DIM * DIM);
    idle(3);
    checks++; if (obs_q.size() != NW) begin failures++; $display("FAIL midrst_count: got %0d expected %0d", obs_q.size(), NW); end
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL midrst_contents: window %0d got %h expected %h", mism, obs_q[mism], exp_q[mism]); end
  endtask

  task automatic test_param_sweep();
    logic [W5-1:0] w;
    int mism;
    obs2_q.delete(); obs5_q.delete(); exp2_q.delete(); exp5_q.delete();
    for (int r = 0; r <= SD - 2; r++)
      for (int c = 0; c <= SD - 2; c++) begin
        w = model_win(SD, 2, r, c, 3);
        exp2_q.push_back({PB'(r), PB'(c), w[W2-1:0]});
      end
    for (int r = 0; r <= SD - 5; r++)
      for (int c = 0; c <= SD - 5; c++) begin
        w = model_win(SD, 5, r, c, 3);
        exp5_q.push_back({PB'(r), PB'(c), w});
      end
    for (int i = 0; i < SD * SD; i++) begin
      if (i % 5 == 4) begin pv_s = 1'b0; @(negedge clk); end
      px_s = GS'(i + 3);
      pv_s = 1'b1;
      @(negedge clk);
    end
    pv_s = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (obs2_q.size() != 49) begin failures++; $display("FAIL k2_count: got %0d expected 49", obs2_q.size()); end
    checks++; if (obs5_q.size() != 16) begin failures++; $display("FAIL k5_count: got %0d expected 16", obs5_q.size()); end
    mism = -1;
    for (int i = 0; i < exp2_q.size() && i < obs2_q.size(); i++)
      if (obs2_q[i] !== exp2_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL k2_contents: window %0d got %h expected %h", mism, obs2_q[mism], exp2_q[mism]); end
    mism = -1;
    for (int i = 0; i < exp5_q.size() && i < obs5_q.size(); i++)
      if (obs5_q[i] !== exp5_q[i]) begin mism = i; break; end
    checks++; if (mism >= 0) begin failures++;
      $display("FAIL k5_contents: window %0d got %h expected %h", mism, obs5_q[mism], exp5_q[mism]); end
    checks++; if ({st2, st5} !== 2'b00) begin failures++; $display("FAIL sweep_end_state: got %b expected 00", {st2, st5}); end
  endtask

  initial begin
    pixel = '0;
    pv    = 1'b0;
    px_s  = '0;
    pv_s  = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Sliding-window generator directly downstream of the pixel input port of the CNN top. It consumes the raster-order greyscale pixel stream (pixel_i / pixel_i_valid) one pixel per accepted cycle. It buffers K-1 image rows in line buffers and emits every valid KxK window, with its output position, to the first convolution layer. There is no backpressure: the consumer must accept one window per cycle.

Parameters:
IMG_DIM, 30, image width and height in pixels (square image)
K, 3, window edge length; K >= 2, K <= IMG_DIM
GS_BITS, 8, bits per greyscale pixel
POS_BITS, 5, width of position outputs; must satisfy 2^POS_BITS > IMG_DIM-K

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
pixel_i  input  GS_BITS  incoming pixel, raster order (row-major, top-left first)
pixel_i_valid  input  1  pixel_i valid this cycle; always accepted
win_o  output  K*K*GS_BITS  window; tap (r,c) at bits [(r*K+c)*GS_BITS +: GS_BITS], r=0 top row, c=0 left column
win_o_valid  output  1  win_o, win_row_o and win_col_o valid this cycle
win_row_o  output  POS_BITS  output row of window, 0..IMG_DIM-K
win_col_o  output  POS_BITS  output column of window, 0..IMG_DIM-K
frame_done_o  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset: win_o=0, win_o_valid=0, win_row_o=0, win_col_o=0, frame_done_o=0. Row and column counters are 0; FSM is in FILL. Line-buffer contents need not be cleared.
- Counters: col_cnt and row_cnt advance only on pixel_i_valid.
  - col_cnt wraps IMG_DIM-1 -> 0 and increments row_cnt.
  - row_cnt wraps IMG_DIM-1 -> 0 at the last pixel of the frame.
  - The next frame starts on the very next valid pixel, with no gap required.
- Storage:
  - K-1 line buffers, each IMG_DIM deep; inferred RAM or shift registers are both acceptable.
  - KxK tap register array. On each accepted pixel, every tap row shifts left by one. The new right column is {line buffer outputs (oldest row on top), pixel_i}.
- FSM:
  - FILL: row_cnt < K-1. No windows are emitted. Moves to STREAM when the pixel at (K-2, IMG_DIM-1) is accepted.
  - STREAM: a window is emitted for each accepted pixel with col_cnt >= K-1.
  - STREAM returns to FILL when the pixel at (IMG_DIM-1, IMG_DIM-1) is accepted.
- Output timing (latency 1):
  - The window whose bottom-right tap is the pixel accepted at edge n appears registered after edge n; win_o_valid is high in that following cycle.
  - win_row_o = row_cnt-(K-1) and win_col_o = col_cnt-(K-1), both sampled at acceptance.
- Windows never straddle a row boundary. Accepted pixels with col_cnt < K-1 only fill taps and emit nothing.
- win_o_valid is low in every cycle not preceded by an emitting acceptance. Gaps in pixel_i_valid produce gaps in win_o_valid and do not alter window contents.
- win_o holds its last value while win_o_valid is low.
- frame_done_o is high together with win_o_valid for window (IMG_DIM-K, IMG_DIM-K) only.
- Count: exactly (IMG_DIM-K+1)^2 windows per frame; 784 for the defaults.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - The partial frame is discarded.
  - The first valid pixel after release is treated as pixel (0,0).
  - No stale line-buffer data may reach a valid window, because FILL gates emission.
- Simultaneous events: the last pixel of frame N is emitted, and its counters wrap, on the same edge. The first pixel of frame N+1 on the next cycle is processed normally.

Test Plan:
- Stimulus: one 30x30 frame, pixel (r,c) = (r*30+c) mod 256, pixel_i_valid held high. Required: first win_o_valid one cycle after pixel 62 is accepted, with row=0, col=0, TL=0x00, centre=0x1F, BR=0x3E. The next window has row=0, col=1, TL=0x01.
- Same frame, final window: frame_done_o is high with row=27, col=27, TL=0x45, centre=0x64, BR=0x83. Exactly 784 valid windows are counted; no valid outputs appear at output columns 28 or 29.
- Same frame with random pixel_i_valid gaps (about 40% idle). Required: the same 784 windows, in the same order and with the same contents, as the gap-free run; win_o_valid is low during gaps.
- Three back-to-back frames, each with a distinct pixel offset, and no idle cycles between frames. Required: 784 windows per frame, with contents matching each frame's own offset. Exactly one frame_done_o pulse per frame.
- Assert rst for 2 cycles after 400 pixels, then send a full frame. Required: outputs are zero during reset, no window is emitted for the aborted frame, and the next frame produces the exact golden 784 windows.
- Parameter sweep K=2 and K=5, IMG_DIM=8. Required: 49 and 16 windows respectively, with contents matching the golden software model.
